pwm_demod: RTL and testbench



---
 rtl/pwm_demod.sv | 121 ++++++++++++
 tb/tb_pwm_demod.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
// pwm_demod: measures high time per PERIOD-clock PWM frame and reports it as a W-bit sample.
// Define PWM_DEMOD_DEGLITCH_EN to insert a 3-clock glitch filter ahead of edge detection.
module pwm_demod #(
   parameter int PERIOD  = 256,
   parameter int W       = 8,
   parameter int TIMEOUT = 2*PERIOD
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         pwm_i,
   output logic [W-1:0] sample_o,
   output logic         valid_o,
   output logic         err_o,
   output logic         locked_o
);
   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] PER_C = CW'(PERIOD);
   localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);
   localparam logic [CW-1:0] MAX_C = CW'(2**W - 1);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   typedef enum logic {IDLE, MEAS} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] per_q, per_d, hi_q, hi_d, per_inc;
   logic [W-1:0]  sample_q, sample_d;
   logic          valid_q, valid_d, err_q, err_d, locked_q, locked_d;
   logic          sync_q, s_q, lvl, lvl_prev_q, rise, tmo, good;

   always_ff @(posedge clk) begin
      if (rst) {sync_q, s_q} <= '0;
      else     {sync_q, s_q} <= {pwm_i, sync_q};
   end

`ifdef PWM_DEMOD_DEGLITCH_EN
   logic [1:0] hist_q;
   logic       filt_q;
   // level follows s_q only once the current and two previous samples agree
   assign lvl = (s_q == hist_q[0] && s_q == hist_q[1]) ? s_q : filt_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= '0;
         filt_q <= 1'b0;
      end else begin
         hist_q <= {hist_q[0], s_q};
         filt_q <= lvl;
      end
   end
`else
   assign lvl = s_q;
`endif

   assign rise = lvl & ~lvl_prev_q;

   always_comb begin
      state_d  = state_q;
      per_d    = per_q;
      hi_d     = hi_q;
      sample_d = sample_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      locked_d = locked_q;
      per_inc  = (per_q == TMO_C) ? per_q : per_q + ONE_C;
      tmo      = per_inc == TMO_C;
      good     = per_q == PER_C;
      if (!en) begin
         state_d = IDLE;
         per_d   = '0;
         hi_d    = '0;
      end else if (rise) begin
         state_d = MEAS;
         per_d   = ONE_C;
         hi_d    = ONE_C;
         if (state_q == MEAS) begin
            valid_d  = good;
            err_d    = !good;
            locked_d = good;
            sample_d = good ? W'(hi_q > MAX_C ? MAX_C : hi_q) : sample_q;
         end
      end else if (tmo) begin
         // no edge for TIMEOUT clocks: report the static level and wait for a fresh rise
         state_d  = IDLE;
         per_d    = '0;
         hi_d     = '0;
         sample_d = {W{lvl}};
         valid_d  = 1'b1;
         locked_d = 1'b0;
      end else begin
         per_d = per_inc;
         hi_d  = (state_q == MEAS && lvl && hi_q != TMO_C) ? hi_q + ONE_C : hi_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         per_q      <= '0;
         hi_q       <= '0;
         sample_q   <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         locked_q   <= 1'b0;
         lvl_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         per_q      <= per_d;
         hi_q       <= hi_d;
         sample_q   <= sample_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         locked_q   <= locked_d;
         lvl_prev_q <= lvl;
      end
   end

   assign sample_o = sample_q;
   assign valid_o  = valid_q;
   assign err_o    = err_q;
   assign locked_o = locked_q;
endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod: scoreboard bench for pwm_demod; frame reports are queued as stimulus is driven.
// Build with PWM_DEMOD_DEGLITCH_EN defined to exercise the glitch filter variant.
module tb_pwm_demod;
   localparam int PERIOD = 256;
`ifdef PWM_DEMOD_DEGLITCH_EN
   localparam int LAT = PERIOD + 5;
   localparam int S_LO = 3;
`else
   localparam int LAT = PERIOD + 3;
   localparam int S_LO = 1;
`endif

   typedef struct packed {
      logic [7:0] s;
      logic       err;
      logic       lock;
   } exp_t;

   logic       clk = 1'b0, rst = 1'b1, en = 1'b1, pwm_i = 1'b0;
   logic [7:0] sample_o;
   logic       valid_o, err_o, locked_o;

   exp_t       q[$];
   int         checks = 0, errors = 0, cyc = 0, nstrobe = 0, last_v = 0, gap = 0;
   int         cur_hi = 0, cur_len = 0, c0 = 0, nv = 0;
   logic       frame_open = 1'b0;
   logic [7:0] exp_s = 8'd0;

   pwm_demod #(.PERIOD(PERIOD), .W(8), .TIMEOUT(2*PERIOD)) dut (
      .clk(clk), .rst(rst), .en(en), .pwm_i(pwm_i),
      .sample_o(sample_o), .valid_o(valid_o), .err_o(err_o), .locked_o(locked_o)
   );

   always #5 clk = ~clk;

   // advance one clock, then compare any strobe against the scoreboard head
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (valid_o || err_o) begin
         nstrobe++;
         if (valid_o) begin
            gap = cyc - last_v;
            last_v = cyc;
         end
         checks++;
         if (valid_o && err_o) begin
            errors++;
            $display("FAIL strobe_overlap cycle %0d valid=%b err=%b, required never both", cyc, valid_o, err_o);
         end else if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe cycle %0d valid=%b err=%b sample=%0d, required no strobe", cyc, valid_o, err_o, sample_o);
         end else begin
            e = q.pop_front();
            if ({sample_o, err_o, locked_o} !== {e.s, e.err, e.lock}) begin
               errors++;
               $display("FAIL report cycle %0d got sample=%0d err=%b locked=%b, required sample=%0d err=%b locked=%b",
                        cyc, sample_o, err_o, locked_o, e.s, e.err, e.lock);
            end
         end
      end
   endtask

   // a new rise closes the previous frame: queue what that frame must report
   task automatic open_frame(input int hi, input int len);
      if (frame_open && en) begin
         if (cur_len == PERIOD) begin
            exp_s = (cur_hi > 255) ? 8'd255 : 8'(cur_hi);
            q.push_back(exp_t'{exp_s, 1'b0, 1'b1});
         end else q.push_back(exp_t'{exp_s, 1'b1, 1'b0});
      end
      frame_open = en;
      cur_hi = hi;
      cur_len = len;
      c0 = cyc;
   endtask

   task automatic drive(input int hi, input int from, input int to, input int gpos);
      for (int i = from; i < to; i++) begin
         pwm_i = (i < hi) || (i == gpos);
         step();
      end
   endtask

   task automatic frame(input int hi, input int len);
      open_frame(hi, len);
      drive(hi, 0, len, -1);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      q.delete();
      frame_open = 1'b0;
      exp_s = 8'd0;
   endtask

   task automatic close_stream();
      open_frame(4, PERIOD);
      drive(4, 0, 4, -1);
      pwm_i = 1'b0;
      for (int i = 0; i < 20 && q.size() != 0; i++) step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain %0d reports still outstanding, required 0", q.size());
      end
      reset_dut();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pwm_i = 1'b0;
      repeat (3) step();
      checks++;
      if (sample_o !== 8'd0) begin errors++; $display("FAIL reset_sample got %0d required 0", sample_o); end
      checks++;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", valid_o); end
      checks++;
      if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b required 0", err_o); end
      checks++;
      if (locked_o !== 1'b0) begin errors++; $display("FAIL reset_locked got %b required 0", locked_o); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_stream_128();
      repeat (6) frame(128, PERIOD);
      checks++;
      if (gap !== PERIOD) begin errors++; $display("FAIL valid_period got %0d required %0d", gap, PERIOD); end
      checks++;
      if (locked_o !== 1'b1) begin errors++; $display("FAIL locked_128 got %b required 1", locked_o); end
      close_stream();
   endtask

   task automatic test_sweep();
      repeat (3) frame(S_LO, PERIOD);
      repeat (3) frame(255, PERIOD);
      close_stream();
   endtask

   task automatic test_static();
      pwm_i = 1'b0;
      reset_dut();
      repeat (2) q.push_back(exp_t'{8'd0, 1'b0, 1'b0});
      drive(0, 0, 1100, -1);
      checks++;
      if (gap !== 2*PERIOD) begin errors++; $display("FAIL static_low_period got %0d required %0d", gap, 2*PERIOD); end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL static_low_count %0d missing, required 0", q.size()); end
      pwm_i = 1'b1;
      reset_dut();
      repeat (2) q.push_back(exp_t'{8'd255, 1'b0, 1'b0});
      drive(2000, 0, 1100, -1);
      checks++;
      if (gap !== 2*PERIOD) begin errors++; $display("FAIL static_high_period got %0d required %0d", gap, 2*PERIOD); end
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL static_high_count %0d missing, required 0", q.size()); end
      pwm_i = 1'b0;
      reset_dut();
   endtask

   task automatic test_bad_frame();
      repeat (3) frame(128, PERIOD);
      frame(100, 200);
      repeat (3) frame(128, PERIOD);
      close_stream();
   endtask

   task automatic test_switch();
      repeat (3) frame(64, PERIOD);
      repeat (3) frame(192, PERIOD);
      close_stream();
   endtask

   task automatic test_reset_mid();
      repeat (2) frame(128, PERIOD);
      open_frame(128, PERIOD);
      drive(128, 0, 200, -1);
      rst = 1'b1;
      step();
      checks++;
      if ({sample_o, valid_o, err_o, locked_o} !== 11'd0) begin
         errors++;
         $display("FAIL mid_reset got sample=%0d valid=%b err=%b locked=%b required all 0", sample_o, valid_o, err_o, locked_o);
      end
      rst = 1'b0;
      q.delete();
      frame_open = 1'b0;
      exp_s = 8'd0;
      drive(128, 200, PERIOD, -1);
      nv = nstrobe;
      frame(128, PERIOD);
      open_frame(128, PERIOD);
      drive(128, 0, 8, -1);
      checks++;
      if (last_v - (c0 - PERIOD) !== LAT || nstrobe !== nv + 1) begin
         errors++;
         $display("FAIL first_valid_latency got %0d strobes=%0d required %0d strobes=1", last_v - (c0 - PERIOD), nstrobe - nv, LAT);
      end
      drive(128, 8, PERIOD, -1);
      close_stream();
   endtask

   task automatic test_en();
      repeat (3) frame(128, PERIOD);
      en = 1'b0;
      nv = nstrobe;
      repeat (4) frame(64, PERIOD);
      checks++;
      if (nstrobe !== nv) begin errors++; $display("FAIL en_strobes got %0d required 0", nstrobe - nv); end
      checks++;
      if (sample_o !== 8'd128) begin errors++; $display("FAIL en_sample_hold got %0d required 128", sample_o); end
      checks++;
      if (locked_o !== 1'b1) begin errors++; $display("FAIL en_locked_hold got %b required 1", locked_o); end
      en = 1'b1;
      repeat (3) frame(64, PERIOD);
      close_stream();
   endtask

   task automatic test_deglitch();
      repeat (4) begin
`ifdef PWM_DEMOD_DEGLITCH_EN
         open_frame(100, PERIOD);
         drive(100, 0, PERIOD, 180);
`else
         open_frame(100, 180);
         drive(100, 0, 180, -1);
         open_frame(1, PERIOD - 180);
         drive(100, 180, PERIOD, 180);
`endif
      end
      close_stream();
   endtask

   initial begin
      test_reset();
      test_stream_128();
      test_sweep();
      test_static();
      test_bad_frame();
      test_switch();
      test_reset_mid();
      test_en();
      test_deglitch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
